// File: rtl/rx_frame_packer_pkg.sv
// rx_frame_packer_pkg
//   Shared types and helpers for the RX frame packer.
//   - state_t        : packer FSM states
//   - LEN_W          : width of the radio length byte
//   - words_for_len  : 16-bit FIFO words needed for a frame of len payload bytes
//                      (length byte + payload, rounded up to whole words)
package rx_frame_packer_pkg;

    localparam int unsigned LEN_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_HI,
        S_LO,
        S_WRITE,
        S_WAIT_HINT,
        S_PAD,
        S_DROP
    } state_t;

    function automatic logic [8:0] words_for_len(input logic [LEN_W-1:0] len);
        return ({1'b0, len} + 9'd2) >> 1;
    endfunction

endpackage

// File: rtl/rx_frame_packer_if.sv
// rx_frame_packer_if
//   Bundles the radio RX byte stream and the RX SRAM FIFO write port.
//   Ports of the bundle:
//     rx_byte, rx_valid, rx_sop, rx_abort : radio -> packer
//     rx_ready                            : packer -> radio
//     SRAM_write, Data_to_sram            : packer -> FIFO (request held until hint)
//     SRAM_hint, SRAM_full, SRAM_count    : FIFO -> packer
//   Modports: master = packer side, slave = radio/FIFO side.
interface rx_frame_packer_if import rx_frame_packer_pkg::*; ();

    logic [LEN_W-1:0] rx_byte;
    logic             rx_valid;
    logic             rx_sop;
    logic             rx_abort;
    logic             rx_ready;

    logic             SRAM_write;
    logic             SRAM_hint;
    logic [15:0]      Data_to_sram;
    logic             SRAM_full;
    logic [10:0]      SRAM_count;

    modport master (
        input  rx_byte, rx_valid, rx_sop, rx_abort,
        output rx_ready,
        output SRAM_write, Data_to_sram,
        input  SRAM_hint, SRAM_full, SRAM_count
    );

    modport slave (
        output rx_byte, rx_valid, rx_sop, rx_abort,
        input  rx_ready,
        input  SRAM_write, Data_to_sram,
        output SRAM_hint, SRAM_full, SRAM_count
    );

endinterface

// File: rtl/rx_frame_packer.sv
// rx_frame_packer
//   Packs a length-prefixed radio frame, received one byte at a time, into
//   16-bit RX FIFO words: {len, b0}, {b1, b2}, ... with the last low byte
//   zero-padded. Frames that do not fit in the FIFO are consumed and dropped
//   whole; aborted frames are zero-padded to their full word count.
//
//   Ports:
//     clk, rst    : system clock, synchronous active-high reset
//     bus         : rx_frame_packer_if.master (RX byte stream + FIFO write port)
//     frame_done  : 1-cycle pulse, last word of a frame acknowledged
//     frame_drop  : 1-cycle pulse, frame discarded without writing
//     frame_err   : 1-cycle pulse with frame_done, frame was aborted and padded
//     drop_cnt    : saturating frame_drop counter (RX_PACKER_STATS_EN only)
//     err_cnt     : saturating frame_err counter  (RX_PACKER_STATS_EN only)
//
//   Optional feature macro: RX_PACKER_STATS_EN
module rx_frame_packer
    import rx_frame_packer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    rx_frame_packer_if.master         bus,
    output logic                      frame_done,
    output logic                      frame_drop,
    output logic                      frame_err
`ifdef RX_PACKER_STATS_EN
    ,
    output logic [15:0]               drop_cnt,
    output logic [15:0]               err_cnt
`endif
);

    localparam logic [11:0] DEPTH = 12'(FIFO_DEPTH);

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_bytes_left;
    logic [15:0]      r_data;
    logic             r_write;
    logic             r_rx_ready;
    logic             r_pad_lo;     // next synthesized pad byte goes to the low half
    logic             r_abort;      // current frame is being padded out
    logic             r_done;
    logic             r_drop;
    logic             r_err;

    logic             w_take;
    logic             w_kill;
    logic [8:0]       w_words;
    logic [11:0]      w_free;
    logic             w_room_ok;

    assign w_take    = bus.rx_valid & r_rx_ready;
    // A new SOP in the middle of a frame is treated like an abort.
    assign w_kill    = bus.rx_abort | (w_take & bus.rx_sop);
    assign w_words   = words_for_len(r_len);
    assign w_free    = ({1'b0, bus.SRAM_count} >= DEPTH) ? '0
                                                         : DEPTH - {1'b0, bus.SRAM_count};
    assign w_room_ok = (w_free >= {3'b000, w_words});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_bytes_left <= '0;
            r_data       <= '0;
            r_write      <= 1'b0;
            r_rx_ready   <= 1'b0;
            r_pad_lo     <= 1'b0;
            r_abort      <= 1'b0;
            r_done       <= 1'b0;
            r_drop       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_drop <= 1'b0;
            r_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_take && bus.rx_sop && !bus.rx_abort) begin
                        r_len      <= bus.rx_byte;
                        r_rx_ready <= 1'b0;
                        r_state    <= S_CHECK;
                    end else begin
                        r_rx_ready <= 1'b1;
                    end
                end

                S_CHECK: begin
                    r_bytes_left <= r_len;
                    r_rx_ready   <= 1'b1;
                    if (r_len == '0) begin
                        r_drop  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (!w_room_ok) begin
                        r_state <= S_DROP;
                    end else begin
                        r_data  <= {r_len, 8'h00};
                        r_state <= S_LO;
                    end
                end

                S_HI: begin
                    if (w_kill) begin
                        r_abort    <= 1'b1;
                        r_pad_lo   <= 1'b0;
                        r_rx_ready <= 1'b0;
                        r_state    <= S_PAD;
                    end else if (w_take) begin
                        r_data[15:8] <= bus.rx_byte;
                        r_bytes_left <= r_bytes_left - 8'd1;
                        if (r_bytes_left == 8'd1) begin
                            r_data[7:0] <= '0;
                            r_rx_ready  <= 1'b0;
                            r_state     <= S_WRITE;
                        end else begin
                            r_state <= S_LO;
                        end
                    end
                end

                S_LO: begin
                    if (w_kill) begin
                        r_abort    <= 1'b1;
                        r_pad_lo   <= 1'b1;
                        r_rx_ready <= 1'b0;
                        r_state    <= S_PAD;
                    end else if (w_take) begin
                        r_data[7:0]  <= bus.rx_byte;
                        r_bytes_left <= r_bytes_left - 8'd1;
                        r_rx_ready   <= 1'b0;
                        r_state      <= S_WRITE;
                    end
                end

                // Mirrors HI/LO with a synthetic 0x00 byte every cycle.
                S_PAD: begin
                    r_bytes_left <= r_bytes_left - 8'd1;
                    if (!r_pad_lo) begin
                        r_data[15:8] <= '0;
                        if (r_bytes_left == 8'd1) begin
                            r_data[7:0] <= '0;
                            r_state     <= S_WRITE;
                        end else begin
                            r_pad_lo <= 1'b1;
                        end
                    end else begin
                        r_data[7:0] <= '0;
                        r_pad_lo    <= 1'b0;
                        r_state     <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    if (!bus.SRAM_full) begin
                        r_write <= 1'b1;
                        r_state <= S_WAIT_HINT;
                    end
                end

                S_WAIT_HINT: begin
                    if (bus.SRAM_hint) begin
                        r_write <= 1'b0;
                        if (r_bytes_left == '0) begin
                            r_done     <= 1'b1;
                            r_err      <= r_abort;
                            r_abort    <= 1'b0;
                            r_rx_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end else if (r_abort) begin
                            r_pad_lo <= 1'b0;
                            r_state  <= S_PAD;
                        end else begin
                            r_rx_ready <= 1'b1;
                            r_state    <= S_HI;
                        end
                    end
                end

                S_DROP: begin
                    if (bus.rx_abort || (w_take && (bus.rx_sop || r_bytes_left == 8'd1))) begin
                        r_drop  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_take) begin
                        r_bytes_left <= r_bytes_left - 8'd1;
                    end
                end

                default: begin
                    r_rx_ready <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready     = r_rx_ready;
    assign bus.SRAM_write   = r_write;
    assign bus.Data_to_sram = r_data;
    assign frame_done       = r_done;
    assign frame_drop       = r_drop;
    assign frame_err        = r_err;

`ifdef RX_PACKER_STATS_EN
    if (1) begin : g_stats
        logic [15:0] r_drop_cnt;
        logic [15:0] r_err_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_drop_cnt <= '0;
                r_err_cnt  <= '0;
            end else begin
                if (r_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 16'd1;
                if (r_err  && r_err_cnt  != '1) r_err_cnt  <= r_err_cnt  + 16'd1;
            end
        end

        assign drop_cnt = r_drop_cnt;
        assign err_cnt  = r_err_cnt;
    end
`endif

endmodule

// File: tb/tb_rx_frame_packer.sv
// tb_rx_frame_packer
//   Directed bench for rx_frame_packer. Expected FIFO words are pushed to a
//   scoreboard queue when a frame is driven and popped when the FIFO
//   responder acknowledges a write.
module tb_rx_frame_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_frame_packer_if bus ();
    logic frame_done, frame_drop, frame_err;
`ifdef RX_PACKER_STATS_EN
    logic [15:0] drop_cnt, err_cnt;
`endif

    rx_frame_packer #(.FIFO_DEPTH(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .frame_done (frame_done),
        .frame_drop (frame_drop),
        .frame_err  (frame_err)
`ifdef RX_PACKER_STATS_EN
        ,
        .drop_cnt   (drop_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];
    int n_done = 0, n_drop = 0, n_err = 0, n_writes = 0;
    int exp_done = 0, exp_drop = 0, exp_err = 0;
    bit hint_en = 1'b1;
    int hint_delay = 1;
    logic [7:0] payload[16];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // FIFO side: acknowledge each request hint_delay cycles after it appears.
    initial begin : responder
        int wcnt;
        logic [15:0] held, e;
        wcnt = 0;
        held = '0;
        bus.SRAM_hint = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.SRAM_hint) begin
                bus.SRAM_hint = 1'b0;
            end else if (!rst && hint_en && bus.SRAM_write) begin
                if (wcnt == 0) held = bus.Data_to_sram;
                wcnt++;
                if (wcnt > 1) check("data_stable", bus.Data_to_sram, held);
                if (wcnt >= hint_delay) begin
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                    check("sram_word", bus.Data_to_sram, e);
                    n_writes++;
                    bus.SRAM_hint = 1'b1;
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin : pulse_mon
        logic p_done, p_drop;
        p_done = 1'b0;
        p_drop = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_done) n_done++;
            if (frame_drop) n_drop++;
            if (frame_err) begin
                n_err++;
                check("err_with_done", 16'(frame_done), 16'd1);
            end
            if (frame_done || frame_drop)
                check("pulse_width", 16'((frame_done & p_done) | (frame_drop & p_drop)), 16'd0);
            p_done = frame_done;
            p_drop = frame_drop;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic sop);
        int t;
        t = 0;
        bus.rx_byte  = b;
        bus.rx_sop   = sop;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("rx_ready_wait", 16'(t < 200), 16'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_sop   = 1'b0;
    endtask

    task automatic wait_end(input int prev);
        int t;
        t = 0;
        while ((n_done + n_drop) == prev && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("frame_end_wait", 16'(t < 400), 16'd1);
    endtask

    // Reference layout: length byte, nvalid received bytes, zeros to len, pad to even.
    task automatic model_frame(input int len, input int nvalid);
        logic [7:0] s[$];
        s.push_back(8'(len));
        for (int i = 0; i < len; i++) s.push_back((i < nvalid) ? payload[i] : 8'h00);
        if ((s.size() % 2) != 0) s.push_back(8'h00);
        for (int i = 0; i < s.size(); i += 2) exp_q.push_back({s[i], s[i+1]});
    endtask

    task automatic send_frame(input int len, input int nbytes);
        send_byte(8'(len), 1'b1);
        for (int i = 0; i < nbytes; i++) send_byte(payload[i], 1'b0);
    endtask

    task automatic check_frame_counts(input string tag);
        check({tag, "_done"}, 16'(n_done), 16'(exp_done));
        check({tag, "_drop"}, 16'(n_drop), 16'(exp_drop));
        check({tag, "_err"},  16'(n_err),  16'(exp_err));
        check({tag, "_queue"}, 16'(exp_q.size()), 16'd0);
    endtask

    initial begin : main
        int prev, w0, t;
        bus.rx_byte = '0; bus.rx_valid = 1'b0; bus.rx_sop = 1'b0; bus.rx_abort = 1'b0;
        bus.SRAM_full = 1'b0; bus.SRAM_count = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_rx_ready", 16'(bus.rx_ready), 16'd0);
        check("rst_write",    16'(bus.SRAM_write), 16'd0);
        check("rst_data",     bus.Data_to_sram, 16'h0000);
        check("rst_pulses",   16'({frame_done, frame_drop, frame_err}), 16'd0);
        rst = 1'b0;

        // len=3, A1 A2 A3
        payload[0] = 8'hA1; payload[1] = 8'hA2; payload[2] = 8'hA3;
        model_frame(3, 3);
        prev = n_done + n_drop;
        send_frame(3, 3);
        wait_end(prev);
        exp_done++;
        check_frame_counts("len3");

        // len=4 with byte-to-request latency and slower hint
        hint_delay = 3;
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33; payload[3] = 8'h44;
        model_frame(4, 4);
        prev = n_done + n_drop;
        send_byte(8'd4, 1'b1);
        send_byte(8'h11, 1'b0);
        check("lat_n1_write", 16'(bus.SRAM_write), 16'd0);
        @(negedge clk);
        check("lat_n2_write", 16'(bus.SRAM_write), 16'd1);
        check("lat_n2_data",  bus.Data_to_sram, 16'h0411);
        for (int i = 1; i < 4; i++) send_byte(payload[i], 1'b0);
        wait_end(prev);
        exp_done++;
        check_frame_counts("len4");
        hint_delay = 1;

        // insufficient space: 1020 used of 1024, len=9 needs 5 words
        bus.SRAM_count = 11'd1020;
        for (int i = 0; i < 9; i++) payload[i] = 8'(8'h50 + i);
        w0 = n_writes;
        prev = n_done + n_drop;
        send_frame(9, 9);
        wait_end(prev);
        exp_drop++;
        check_frame_counts("nospace");
        check("nospace_writes", 16'(n_writes), 16'(w0));
`ifdef RX_PACKER_STATS_EN
        check("nospace_drop_cnt", drop_cnt, 16'(exp_drop));
`endif
        bus.SRAM_count = '0;

        // len=0
        w0 = n_writes;
        prev = n_done + n_drop;
        send_byte(8'd0, 1'b1);
        wait_end(prev);
        exp_drop++;
        check_frame_counts("len0");
        check("len0_writes", 16'(n_writes), 16'(w0));

        // len=6, abort after two data bytes
        payload[0] = 8'hB1; payload[1] = 8'hB2;
        model_frame(6, 2);
        prev = n_done + n_drop;
        send_frame(6, 2);
        bus.rx_abort = 1'b1;
        @(negedge clk);
        bus.rx_abort = 1'b0;
        wait_end(prev);
        exp_done++;
        exp_err++;
        check_frame_counts("abort");
`ifdef RX_PACKER_STATS_EN
        check("abort_err_cnt", err_cnt, 16'(exp_err));
`endif

        // SRAM_full stalls the write for 10 cycles
        bus.SRAM_full = 1'b1;
        payload[0] = 8'hC5;
        model_frame(1, 1);
        prev = n_done + n_drop;
        send_frame(1, 1);
        for (int i = 0; i < 10; i++) begin
            check("full_write_low", 16'(bus.SRAM_write), 16'd0);
            check("full_data_hold", bus.Data_to_sram, 16'h01C5);
            @(negedge clk);
        end
        bus.SRAM_full = 1'b0;
        wait_end(prev);
        exp_done++;
        check_frame_counts("full");

        // reset while waiting for the hint
        hint_enacted: begin
            hint_en = 1'b0;
            send_byte(8'd2, 1'b1);
            send_byte(8'hD1, 1'b0);
            t = 0;
            while (!bus.SRAM_write && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("wh_req_wait", 16'(t < 20), 16'd1);
            repeat (3) @(negedge clk);
            check("wh_write_held", 16'(bus.SRAM_write), 16'd1);
            check("wh_data_held",  bus.Data_to_sram, 16'h02D1);
            rst = 1'b1;
            @(negedge clk);
            check("wh_rst_write",    16'(bus.SRAM_write), 16'd0);
            check("wh_rst_data",     bus.Data_to_sram, 16'h0000);
            check("wh_rst_rx_ready", 16'(bus.rx_ready), 16'd0);
            check("wh_rst_pulses",   16'({frame_done, frame_drop, frame_err}), 16'd0);
`ifdef RX_PACKER_STATS_EN
            check("wh_rst_drop_cnt", drop_cnt, 16'd0);
            check("wh_rst_err_cnt",  err_cnt, 16'd0);
`endif
            rst = 1'b0;
            hint_en = 1'b1;
        end

        // recovery frame after reset
        payload[0] = 8'hE1; payload[1] = 8'hE2;
        model_frame(2, 2);
        prev = n_done + n_drop;
        send_frame(2, 2);
        wait_end(prev);
        exp_done++;
        check_frame_counts("recover");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
